// File: rtl/layer0_input_quantizer_if.sv
// Streaming handshake bundle between the feature source, the quantizer and layer 0.
interface layer0_input_quantizer_if #(
  parameter int unsigned IN_W  = 12,
  parameter int unsigned OUT_W = 32
);
  logic [IN_W-1:0]  s_data;
  logic             s_valid;
  logic             s_last;
  logic             s_ready;
  logic [OUT_W-1:0] m_data;
  logic             m_valid;
  logic             m_ready;

  // Quantizer side: consumes samples, produces packed frames.
  modport slave (
    input  s_data, s_valid, s_last, m_ready,
    output s_ready, m_data, m_valid
  );

  // Environment side: produces samples, consumes packed frames.
  modport master (
    output s_data, s_valid, s_last, m_ready,
    input  s_ready, m_data, m_valid
  );
endinterface

// File: rtl/layer0_input_quantizer.sv
// Quantizes a stream of signed features to BITS-bit codes and packs each
// complete frame into the flat layer-0 input vector; malformed frames are
// dropped and counted.
module layer0_input_quantizer #(
  parameter int unsigned NUM_FEATURES = 16,
  parameter int unsigned IN_W         = 12,
  parameter int unsigned BITS         = 2,
  parameter int unsigned SHIFT        = 8,
  parameter int unsigned ERR_W        = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  layer0_input_quantizer_if.slave   bus,
  output logic                      frame_err,
  output logic [ERR_W-1:0]          err_count
);

  localparam int unsigned OUT_W = NUM_FEATURES * BITS;
  localparam int unsigned IDX_W = (NUM_FEATURES > 1) ? $clog2(NUM_FEATURES) : 1;
  localparam int unsigned QW    = IN_W + 2;

  localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(NUM_FEATURES - 1);
  localparam logic signed [QW-1:0]  HALF_Q   = QW'(2 ** (BITS - 1));
  localparam logic signed [QW-1:0]  MAX_Q    = QW'(2 ** BITS - 1);
  localparam logic [ERR_W-1:0]      ERR_MAX  = {ERR_W{1'b1}};

  logic [IDX_W-1:0] idx_q, idx_d;
  logic [OUT_W-1:0] asm_q, asm_d;
  logic [OUT_W-1:0] m_data_q, m_data_d;
  logic             m_valid_q, m_valid_d;
  logic             frame_err_q, frame_err_d;
  logic [ERR_W-1:0] err_count_q, err_count_d;

  logic signed [IN_W:0] s_ext_c;
  logic signed [IN_W:0] y_c;
  logic signed [QW-1:0] q_wide_c;
  logic [BITS-1:0]      q_c;
  logic                 at_last_c;
  logic                 s_ready_c;
  logic                 accept_c;
  logic [OUT_W-1:0]     asm_merged_c;

  // Shift, re-centre and saturate the incoming sample to a BITS-bit code.
  always_comb begin
    s_ext_c  = $signed({bus.s_data[IN_W-1], bus.s_data});
    y_c      = s_ext_c >>> SHIFT;
    q_wide_c = $signed({y_c[IN_W], y_c}) + HALF_Q;
    if (q_wide_c[QW-1]) begin
      q_c = '0;
    end else if (q_wide_c > MAX_Q) begin
      q_c = '1;
    end else begin
      q_c = q_wide_c[BITS-1:0];
    end
  end

  // Stall only the closing sample while the output slot is full and not draining.
  always_comb begin
    at_last_c = (idx_q == LAST_IDX);
    s_ready_c = !(at_last_c && m_valid_q && !bus.m_ready);
    accept_c  = bus.s_valid && s_ready_c;
  end

  // Frame assembly, frame close classification, output slot and error counter.
  always_comb begin
    idx_d        = idx_q;
    asm_d        = asm_q;
    m_data_d     = m_data_q;
    m_valid_d    = m_valid_q;
    frame_err_d  = 1'b0;
    err_count_d  = err_count_q;
    asm_merged_c = asm_q;
    asm_merged_c[idx_q*BITS +: BITS] = q_c;

    if (m_valid_q && bus.m_ready) begin
      m_valid_d = 1'b0;
    end

    if (accept_c) begin
      asm_d = asm_merged_c;
      if (at_last_c && bus.s_last) begin
        m_data_d  = asm_merged_c;
        m_valid_d = 1'b1;
        idx_d     = '0;
      end else if (at_last_c || bus.s_last) begin
        idx_d       = '0;
        frame_err_d = 1'b1;
        if (err_count_q != ERR_MAX) begin
          err_count_d = err_count_q + ERR_W'(1);
        end
      end else begin
        idx_d = idx_q + IDX_W'(1);
      end
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q       <= '0;
      asm_q       <= '0;
      m_data_q    <= '0;
      m_valid_q   <= 1'b0;
      frame_err_q <= 1'b0;
      err_count_q <= '0;
    end else begin
      idx_q       <= idx_d;
      asm_q       <= asm_d;
      m_data_q    <= m_data_d;
      m_valid_q   <= m_valid_d;
      frame_err_q <= frame_err_d;
      err_count_q <= err_count_d;
    end
  end

  assign bus.s_ready = s_ready_c;
  assign bus.m_data  = m_data_q;
  assign bus.m_valid = m_valid_q;
  assign frame_err   = frame_err_q;
  assign err_count   = err_count_q;

endmodule

// File: tb/tb_layer0_input_quantizer.sv
// Directed bench for layer0_input_quantizer with a 4-feature, 2-bit configuration.
module tb_layer0_input_quantizer;

  localparam int unsigned NF    = 4;
  localparam int unsigned IN_W  = 12;
  localparam int unsigned BITS  = 2;
  localparam int unsigned SHIFT = 8;
  localparam int unsigned ERR_W = 8;
  localparam int unsigned OUT_W = NF * BITS;

  logic             clk;
  logic             rst_n;
  logic             frame_err;
  logic [ERR_W-1:0] err_count;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  int unsigned pulses;

  layer0_input_quantizer_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bus ();

  layer0_input_quantizer #(
    .NUM_FEATURES(NF),
    .IN_W(IN_W),
    .BITS(BITS),
    .SHIFT(SHIFT),
    .ERR_W(ERR_W)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus),
    .frame_err(frame_err),
    .err_count(err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Offer one sample starting at a negedge; returns at the negedge after it is accepted.
  task automatic send(input logic [IN_W-1:0] d, input logic l);
    int unsigned guard;
    guard = 0;
    bus.s_data  = d;
    bus.s_last  = l;
    bus.s_valid = 1'b1;
    #1;
    while (!bus.s_ready && guard < 50) begin
      @(negedge clk);
      #1;
      guard++;
    end
    if (guard >= 50) check("s_ready_timeout", 32'(guard), 32'd0);
    @(negedge clk);
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
  endtask

  task automatic idle(input int unsigned n);
    for (int i = 0; i < int'(n); i++) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n       = 1'b0;
    bus.s_data  = '0;
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
    bus.m_ready = 1'b0;
    idle(3);
    check("rst_m_valid",   32'(bus.m_valid), 32'd0);
    check("rst_m_data",    32'(bus.m_data),  32'h00);
    check("rst_err_count", 32'(err_count),   32'd0);
    check("rst_frame_err", 32'(frame_err),   32'd0);
    check("rst_s_ready",   32'(bus.s_ready), 32'd1);
    rst_n = 1'b1;
    idle(1);

    // 1: quantization and packing
    bus.m_ready = 1'b1;
    send(12'h7FF, 1'b0);
    send(12'h800, 1'b0);
    send(12'h000, 1'b0);
    check("t1_no_early_valid", 32'(bus.m_valid), 32'd0);
    send(12'hF00, 1'b1);
    check("t1_m_valid", 32'(bus.m_valid), 32'd1);
    check("t1_m_data",  32'(bus.m_data),  32'h63);
    idle(1);
    check("t1_single_valid", 32'(bus.m_valid), 32'd0);

    // 2: backpressure with two frames
    bus.m_ready = 1'b0;
    send(12'h100, 1'b0);
    send(12'h000, 1'b0);
    send(12'hE00, 1'b0);
    send(12'h0FF, 1'b1);
    check("t2_a_valid", 32'(bus.m_valid), 32'd1);
    check("t2_a_data",  32'(bus.m_data),  32'h8B);
    send(12'hFFF, 1'b0);
    check("t2_b1_ready", 32'(bus.s_ready), 32'd1);
    send(12'h1FF, 1'b0);
    check("t2_b2_ready", 32'(bus.s_ready), 32'd1);
    send(12'hF01, 1'b0);
    check("t2_b3_ready_low", 32'(bus.s_ready), 32'd0);
    check("t2_a_held", 32'(bus.m_data), 32'h8B);
    bus.s_data  = 12'h080;
    bus.s_last  = 1'b1;
    bus.s_valid = 1'b1;
    #1;
    check("t2_stall_ready", 32'(bus.s_ready), 32'd0);
    @(negedge clk);
    check("t2_stall_data",  32'(bus.m_data),  32'h8B);
    check("t2_stall_valid", 32'(bus.m_valid), 32'd1);
    bus.m_ready = 1'b1;
    #1;
    check("t2_drain_ready", 32'(bus.s_ready), 32'd1);
    @(negedge clk);
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
    bus.m_ready = 1'b0;
    check("t2_b_valid", 32'(bus.m_valid), 32'd1);
    check("t2_b_data",  32'(bus.m_data),  32'h9D);
    idle(1);
    check("t2_b_held", 32'(bus.m_data), 32'h9D);
    bus.m_ready = 1'b1;
    idle(1);
    check("t2_b_drained", 32'(bus.m_valid), 32'd0);
    check("t2_no_err", 32'(err_count), 32'd0);

    // 3: short frame
    send(12'h000, 1'b0);
    send(12'h000, 1'b1);
    check("t3_frame_err", 32'(frame_err),   32'd1);
    check("t3_err_count", 32'(err_count),   32'd1);
    check("t3_no_valid",  32'(bus.m_valid), 32'd0);
    idle(1);
    check("t3_err_pulse_end", 32'(frame_err), 32'd0);
    for (int i = 0; i < 4; i++) send(12'h7FF, (i == 3) ? 1'b1 : 1'b0);
    check("t3_next_valid", 32'(bus.m_valid), 32'd1);
    check("t3_next_data",  32'(bus.m_data),  32'hFF);
    idle(1);

    // 4: long frame
    for (int i = 0; i < 4; i++) send(12'h000, 1'b0);
    check("t4_frame_err", 32'(frame_err),   32'd1);
    check("t4_err_count", 32'(err_count),   32'd2);
    check("t4_no_valid",  32'(bus.m_valid), 32'd0);
    send(12'h000, 1'b0);
    send(12'h100, 1'b0);
    send(12'hF00, 1'b0);
    send(12'h800, 1'b1);
    check("t4_realign_valid", 32'(bus.m_valid), 32'd1);
    check("t4_realign_data",  32'(bus.m_data),  32'h1E);
    check("t4_realign_noerr", 32'(frame_err),   32'd0);
    idle(1);

    // 5: error counter saturation
    pulses = 0;
    for (int i = 0; i < 260; i++) begin
      send(12'h123, 1'b0);
      pulses += 32'(frame_err);
      send(12'h456, 1'b1);
      pulses += 32'(frame_err);
    end
    check("t5_err_sat",    32'(err_count), 32'd255);
    check("t5_pulse_count", pulses,        32'd260);
    check("t5_no_valid",   32'(bus.m_valid), 32'd0);
    idle(1);

    // 6: reset mid-frame with a held frame
    bus.m_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(12'h7FF, (i == 3) ? 1'b1 : 1'b0);
    check("t6_held_valid", 32'(bus.m_valid), 32'd1);
    send(12'h000, 1'b0);
    send(12'h000, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_async_valid", 32'(bus.m_valid), 32'd0);
    check("t6_async_data",  32'(bus.m_data),  32'h00);
    check("t6_async_err",   32'(err_count),   32'd0);
    check("t6_async_ready", 32'(bus.s_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    bus.m_ready = 1'b1;
    send(12'h7FF, 1'b0);
    send(12'h800, 1'b0);
    send(12'h000, 1'b0);
    send(12'hF00, 1'b1);
    check("t6_fresh_valid", 32'(bus.m_valid), 32'd1);
    check("t6_fresh_data",  32'(bus.m_data),  32'h63);
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
